aes_dec_round_bs: RTL

- Byte-serial AES inverse round: the decrypt-side counterpart of the byte-serial encrypt round.
- Per block it applies InvShiftRows, then InvSubBytes, then AddRoundKey, then InvMixColumns. InvMixColumns is skipped when the block is flagged as the final round.
- Accepts 16 state bytes plus 16 round-key bytes, one of each per beat, and returns 16 result bytes.
- Sits between the decrypt key-schedule byte stream and the decrypt round controller.

---
 rtl/aes_dec_pkg.sv | 33 +++
 rtl/inv_mix_column.sv | 19 +
 rtl/sub_bytes.sv | 53 +++++
 rtl/aes_dec_round_bs.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the byte-serial AES inverse round.
package aes_dec_pkg;

   localparam int unsigned NB = 16;

   localparam logic [7:0] GF_RED = 8'h1B;

   localparam logic [7:0] IMC_C0 = 8'h0E;
   localparam logic [7:0] IMC_C1 = 8'h0B;
   localparam logic [7:0] IMC_C2 = 8'h0D;
   localparam logic [7:0] IMC_C3 = 8'h09;

   typedef enum logic [1:0] {
      LOAD,
      PROC,
      DRAIN
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using an xtime chain (a*2, a*4, a*8).
   function automatic logic [7:0] gf_mul_coef(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
             (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational AES InvMixColumns on one column; byte r of the column sits at bits [8r+7:8r].
module inv_mix_column
   import aes_dec_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   always_comb begin
      col_o = '0;
      for (int r = 0; r < 4; r++) begin
         col_o[8*r +: 8] = gf_mul_coef(col_i[8*r +: 8],           IMC_C0[3:0]) ^
                           gf_mul_coef(col_i[8*((r + 1) % 4) +: 8], IMC_C1[3:0]) ^
                           gf_mul_coef(col_i[8*((r + 2) % 4) +: 8], IMC_C2[3:0]) ^
                           gf_mul_coef(col_i[8*((r + 3) % 4) +: 8], IMC_C3[3:0]);
      end
   end

endmodule

// File: rtl/sub_bytes.sv
// AES byte substitution: forward S-box (mode_i=0) or inverse S-box (mode_i=1),
// computed as GF(2^8) inversion combined with the affine map.
module sub_bytes
   import aes_dec_pkg::*;
(
   input  logic       mode_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // a^254 == a^-1 for a != 0, and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   always_comb begin
      data_o = 8'h00;
      if (mode_i) data_o = gf_inv(affine_inv(data_i));
      else        data_o = affine_fwd(gf_inv(data_i));
   end

endmodule

// File: rtl/aes_dec_round_bs.sv
// Byte-serial AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Define AES_DEC_PIPE_EN to register the column after AddRoundKey (PROC takes 5 cycles).
module aes_dec_round_bs
   import aes_dec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_key,
   input  logic       last_round,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last
);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_q, last_d;

   logic [7:0] st_q  [NB];
   logic [7:0] st_d  [NB];
   logic [7:0] key_q [NB];
   logic [7:0] key_d [NB];
   logic [7:0] res_q [NB];
   logic [7:0] res_d [NB];

   logic [1:0]  ark_c;
   logic [1:0]  wr_c;
   logic        wr_ok;
   logic [31:0] ark_col;
   logic [31:0] mix_in;
   logic [31:0] mix_out;
   logic [31:0] col_res;

   // Row r of column c reads state column (c - r) mod 4, i.e. InvShiftRows on the fly.
   for (genvar r = 0; r < 4; r++) begin : g_row
      logic [1:0] src_c;
      logic [7:0] sb_out;
      assign src_c = ark_c - 2'(r);
      sub_bytes u_sub_bytes (
         .mode_i (1'b1),
         .data_i (st_q[{src_c, 2'(r)}]),
         .data_o (sb_out)
      );
      assign ark_col[8*r +: 8] = sb_out ^ key_q[{ark_c, 2'(r)}];
   end

`ifdef AES_DEC_PIPE_EN
   localparam logic [3:0] PROC_LAST = 4'd4;
   logic [31:0] pipe_q, pipe_d;

   // Cycle k computes column k into the register while column k-1 is written back.
   assign pipe_d = ark_col;
   assign ark_c  = cnt_q[1:0];
   assign mix_in = pipe_q;
   assign wr_c   = 2'(cnt_q - 4'd1);
   assign wr_ok  = (cnt_q != 4'd0);

   always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
   end
`else
   localparam logic [3:0] PROC_LAST = 4'd3;

   assign ark_c  = cnt_q[1:0];
   assign mix_in = ark_col;
   assign wr_c   = cnt_q[1:0];
   assign wr_ok  = 1'b1;
`endif

   inv_mix_column u_inv_mix_column (
      .col_i (mix_in),
      .col_o (mix_out)
   );

   assign col_res = last_q ? mix_in : mix_out;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      st_d      = st_q;
      key_d     = key_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = 8'h00;

      unique case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d[cnt_q]  = in_data;
               key_d[cnt_q] = in_key;
               if (cnt_q == 4'd0) last_d = last_round;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(NB - 1)) state_d = PROC;
            end
         end
         PROC: begin
            if (wr_ok) begin
               for (int r = 0; r < 4; r++) res_d[{wr_c, 2'(r)}] = col_res[8*r +: 8];
            end
            if (cnt_q == PROC_LAST) begin
               cnt_d   = 4'd0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = res_q[cnt_q];
            out_last  = (cnt_q == 4'(NB - 1));
            if (out_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(NB - 1)) state_d = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= 4'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Data buffers carry no reset; the FSM never emits them before a full reload.
   always_ff @(posedge clk) begin
      st_q  <= st_d;
      key_q <= key_d;
      res_q <= res_d;
   end

endmodule
